// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client burst memory arbiter.
package mem_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE_WR  = 2'd1,
        ST_ISSUE_RD  = 2'd2,
        ST_NULL_DONE = 2'd3
    } arb_state_t;

    // Request slots in fixed round-robin order: bit 1 selects the client,
    // bit 0 selects read (1) or write (0).
    localparam int NUM_SLOTS = 4;
    localparam logic [1:0] SLOT_C0_WR = 2'd0;
    localparam logic [1:0] SLOT_C0_RD = 2'd1;
    localparam logic [1:0] SLOT_C1_WR = 2'd2;
    localparam logic [1:0] SLOT_C1_RD = 2'd3;

    // True when the slot carries a read burst.
    function automatic logic slot_is_rd(input logic [1:0] slot);
        return slot[0];
    endfunction

endpackage

// File: rtl/mem_burst_arbiter_if.sv
// Burst memory port bundle, used for both client ports and the shared master port.
//
// Handshake: the requester raises *_burst_req (level) together with stable
// len/addr and holds them until the responder pulses *_burst_finish for one
// cycle. Write data is consumed in every cycle wr_burst_data_req is high; read
// data is valid in every cycle rd_burst_data_valid is high. There is no
// back-pressure on the data strobes.
interface mem_burst_arbiter_if #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 32,
    parameter int LEN_BITS      = 10
);
    logic                     rd_burst_req;
    logic                     wr_burst_req;
    logic [LEN_BITS-1:0]      rd_burst_len;
    logic [LEN_BITS-1:0]      wr_burst_len;
    logic [ADDR_BITS-1:0]     rd_burst_addr;
    logic [ADDR_BITS-1:0]     wr_burst_addr;
    logic [MEM_DATA_BITS-1:0] wr_burst_data;
    logic                     wr_burst_data_req;
    logic                     rd_burst_data_valid;
    logic [MEM_DATA_BITS-1:0] rd_burst_data;
    logic                     rd_burst_finish;
    logic                     wr_burst_finish;

    // Requester side (client, or the arbiter towards the AXI master).
    modport master (
        output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
               rd_burst_addr, wr_burst_addr, wr_burst_data,
        input  wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
               rd_burst_finish, wr_burst_finish
    );

    // Responder side (the arbiter towards a client, or the AXI master).
    modport slave (
        input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
               rd_burst_addr, wr_burst_addr, wr_burst_data,
        output wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
               rd_burst_finish, wr_burst_finish
    );
endinterface

// File: rtl/mem_burst_arbiter_rr_pick4.sv
// Four-way round-robin picker: searches from (last+1) mod 4 for the first set request.
module rr_pick4
    import mem_arb_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] req,
    input  logic [1:0]           last,
    output logic                 valid,
    output logic [1:0]           winner
);

    // Walk the four slots starting just after the last grant; first hit wins.
    always_comb begin
        valid  = 1'b0;
        winner = last;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            if (!valid && req[2'(last + 2'(i))]) begin
                valid  = 1'b1;
                winner = 2'(last + 2'(i));
            end
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Shares one burst memory port between two clients, each with independent
// read and write requests. One transfer in flight; bursts forwarded unchanged.
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DATA_BITS  = 64,
    parameter int ADDR_BITS      = 32,
    parameter int LEN_BITS       = 10,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  mem_clk,
    input  logic                  rst,
    mem_burst_arbiter_if.slave    c0,
    mem_burst_arbiter_if.slave    c1,
    mem_burst_arbiter_if.master   m,
    output logic                  busy,
    output logic [1:0]            grant_slot,
    output logic                  timeout,
    output arb_state_t            dbg_state
);

    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES);

    arb_state_t             state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;
    logic                   m_rd_req_q, m_rd_req_d;
    logic                   m_wr_req_q, m_wr_req_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [LEN_BITS-1:0]    len_q, len_d;
    logic [31:0]            wd_q, wd_d;

    logic [NUM_SLOTS-1:0]   req_vec;
    logic                   pick_valid;
    logic [1:0]             pick_slot;
    logic [ADDR_BITS-1:0]   pick_addr;
    logic [LEN_BITS-1:0]    pick_len;
    logic                   issue_wr, issue_rd, null_done;
    logic [NUM_SLOTS-1:0]   fin_vec;
    logic [MEM_DATA_BITS-1:0] wr_data_mux;

    assign req_vec[SLOT_C0_WR] = c0.wr_burst_req;
    assign req_vec[SLOT_C0_RD] = c0.rd_burst_req;
    assign req_vec[SLOT_C1_WR] = c1.wr_burst_req;
    assign req_vec[SLOT_C1_RD] = c1.rd_burst_req;

    rr_pick4 u_pick (
        .req    (req_vec),
        .last   (grant_q),
        .valid  (pick_valid),
        .winner (pick_slot)
    );

    // Address/length of the slot the picker would grant this cycle.
    always_comb begin
        case (pick_slot)
            SLOT_C0_WR: begin pick_addr = c0.wr_burst_addr; pick_len = c0.wr_burst_len; end
            SLOT_C0_RD: begin pick_addr = c0.rd_burst_addr; pick_len = c0.rd_burst_len; end
            SLOT_C1_WR: begin pick_addr = c1.wr_burst_addr; pick_len = c1.wr_burst_len; end
            default:    begin pick_addr = c1.rd_burst_addr; pick_len = c1.rd_burst_len; end
        endcase
    end

    // Next-state logic: grant in IDLE, wait for the master finish in ISSUE,
    // one bookkeeping cycle for zero-length bursts. Watchdog runs during ISSUE.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        timeout_d  = timeout_q;
        m_rd_req_d = m_rd_req_q;
        m_wr_req_d = m_wr_req_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wd_d       = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_slot;
                    busy_d  = 1'b1;
                    addr_d  = pick_addr;
                    len_d   = pick_len;
                    wd_d    = '0;
                    if (pick_len == '0) begin
                        state_d = ST_NULL_DONE;
                    end else if (slot_is_rd(pick_slot)) begin
                        state_d    = ST_ISSUE_RD;
                        m_rd_req_d = 1'b1;
                    end else begin
                        state_d    = ST_ISSUE_WR;
                        m_wr_req_d = 1'b1;
                    end
                end
            end
            ST_ISSUE_WR, ST_ISSUE_RD: begin
                // Saturate at the limit so the counter never wraps.
                if (wd_q != WD_LIMIT) begin
                    wd_d = wd_q + 32'd1;
                end
                if (TIMEOUT_CYCLES != 0 && wd_d == WD_LIMIT) begin
                    timeout_d = 1'b1;
                end
                if ((state_q == ST_ISSUE_WR && m.wr_burst_finish) ||
                    (state_q == ST_ISSUE_RD && m.rd_burst_finish)) begin
                    m_rd_req_d = 1'b0;
                    m_wr_req_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset leaves grant at slot 3 so the first
    // search starts at slot 0.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= SLOT_C1_RD;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            m_rd_req_q <= 1'b0;
            m_wr_req_q <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            m_rd_req_q <= m_rd_req_d;
            m_wr_req_q <= m_wr_req_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wd_q       <= wd_d;
        end
    end

    assign issue_wr  = (state_q == ST_ISSUE_WR);
    assign issue_rd  = (state_q == ST_ISSUE_RD);
    assign null_done = (state_q == ST_NULL_DONE);

    // Finish pulse for the granted slot; master finishes outside a matching
    // ISSUE state are ignored, and reset suppresses the pulse.
    always_comb begin
        fin_vec = '0;
        if (!rst && ((issue_wr && m.wr_burst_finish) ||
                     (issue_rd && m.rd_burst_finish) || null_done)) begin
            fin_vec[grant_q] = 1'b1;
        end
    end

    assign c0.wr_burst_finish = fin_vec[SLOT_C0_WR];
    assign c0.rd_burst_finish = fin_vec[SLOT_C0_RD];
    assign c1.wr_burst_finish = fin_vec[SLOT_C1_WR];
    assign c1.rd_burst_finish = fin_vec[SLOT_C1_RD];

    // Data strobes go only to the granted client while its transfer is issued.
    assign c0.wr_burst_data_req   = issue_wr && (grant_q == SLOT_C0_WR) && m.wr_burst_data_req;
    assign c1.wr_burst_data_req   = issue_wr && (grant_q == SLOT_C1_WR) && m.wr_burst_data_req;
    assign c0.rd_burst_data_valid = issue_rd && (grant_q == SLOT_C0_RD) && m.rd_burst_data_valid;
    assign c1.rd_burst_data_valid = issue_rd && (grant_q == SLOT_C1_RD) && m.rd_burst_data_valid;
    assign c0.rd_burst_data       = m.rd_burst_data;
    assign c1.rd_burst_data       = m.rd_burst_data;

    assign wr_data_mux     = grant_q[1] ? c1.wr_burst_data : c0.wr_burst_data;
    assign m.wr_burst_data = wr_data_mux;

    assign m.rd_burst_req  = m_rd_req_q;
    assign m.wr_burst_req  = m_wr_req_q;
    assign m.rd_burst_addr = addr_q;
    assign m.wr_burst_addr = addr_q;
    assign m.rd_burst_len  = len_q;
    assign m.wr_burst_len  = len_q;

    assign busy       = busy_q;
    assign grant_slot = grant_q;
    assign timeout    = timeout_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter with a grant scoreboard and a simple
// memory-side responder model.
module tb_mem_burst_arbiter;
    import mem_arb_pkg::*;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int LW = 10;
    localparam int TO = 50;
    localparam int KW = 2 + AW + LW;

    logic mem_clk = 1'b0;
    logic rst = 1'b1;
    always #5 mem_clk = ~mem_clk;

    mem_burst_arbiter_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW)) c0_if ();
    mem_burst_arbiter_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW)) c1_if ();
    mem_burst_arbiter_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW)) m_if ();

    logic       busy;
    logic [1:0] grant_slot;
    logic       timeout;
    arb_state_t dbg_state;

    mem_burst_arbiter #(
        .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .mem_clk    (mem_clk),
        .rst        (rst),
        .c0         (c0_if),
        .c1         (c1_if),
        .m          (m_if),
        .busy       (busy),
        .grant_slot (grant_slot),
        .timeout    (timeout),
        .dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [KW-1:0] exp_q[$];
    int fin_cnt[4];
    int wr_dreq_cnt[2];
    int rd_valid_cnt[2];
    int m_wr_rise;
    int m_rd_rise;
    int onehot_err;
    int route_err;
    bit c0_rd_repeat = 1'b0;
    bit withhold = 1'b0;
    logic [DW-1:0] rd_pattern = '0;
    logic prev_m_rd = 1'b0;
    logic prev_m_wr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag, input string what);
        n_checks++;
        n_errors++;
        $error("FAIL %s: %s", tag, what);
    endtask

    task automatic pop_compare(input string tag, input logic [KW-1:0] obs);
        if (exp_q.size() == 0) begin
            fail_now(tag, $sformatf("observed grant 0x%0h, expected none", obs));
        end else begin
            chk(tag, 64'(obs), 64'(exp_q.pop_front()));
        end
    endtask

    function automatic logic [KW-1:0] key(input logic [1:0] s, input logic [AW-1:0] a,
                                          input logic [LW-1:0] l);
        return {s, a, l};
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) fin_cnt[i] = 0;
        for (int i = 0; i < 2; i++) begin
            wr_dreq_cnt[i]  = 0;
            rd_valid_cnt[i] = 0;
        end
        m_wr_rise  = 0;
        m_rd_rise  = 0;
        onehot_err = 0;
        route_err  = 0;
    endtask

    task automatic to_drive();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge mem_clk);
        #1;
    endtask

    task automatic do_reset();
        to_drive();
        rst = 1'b1;
        withhold = 1'b0;
        c0_rd_repeat = 1'b0;
        c0_if.rd_burst_req = 1'b0;
        c0_if.wr_burst_req = 1'b0;
        c1_if.rd_burst_req = 1'b0;
        c1_if.wr_burst_req = 1'b0;
        repeat (2) to_drive();
        rst = 1'b0;
    endtask

    // Wait until the arbiter is idle and no client holds a request.
    task automatic wait_quiet(input string tag, input int budget);
        int k;
        k = 0;
        while (!(busy === 1'b0 && !c0_if.rd_burst_req && !c0_if.wr_burst_req &&
                 !c1_if.rd_burst_req && !c1_if.wr_burst_req) && k < budget) begin
            to_sample();
            k++;
        end
        if (k >= budget) fail_now(tag, $sformatf("no completion within %0d cycles", budget));
    endtask

    // Memory-side responder: write bursts get len data strobes back to back,
    // read bursts get len valid beats on alternate cycles, then a finish pulse.
    initial begin : master_model
        int n;
        m_if.wr_burst_data_req   = 1'b0;
        m_if.rd_burst_data_valid = 1'b0;
        m_if.rd_burst_data       = '0;
        m_if.rd_burst_finish     = 1'b0;
        m_if.wr_burst_finish     = 1'b0;
        forever begin
            @(posedge mem_clk);
            #1;
            if (!rst && m_if.wr_burst_req) begin
                n = int'(m_if.wr_burst_len);
                for (int i = 0; i < n && !rst; i++) begin
                    m_if.wr_burst_data_req = 1'b1;
                    @(posedge mem_clk);
                    #1;
                end
                m_if.wr_burst_data_req = 1'b0;
                while (withhold && !rst) begin
                    @(posedge mem_clk);
                    #1;
                end
                if (!rst) begin
                    m_if.wr_burst_finish = 1'b1;
                    @(posedge mem_clk);
                    #1;
                    m_if.wr_burst_finish = 1'b0;
                end
            end else if (!rst && m_if.rd_burst_req) begin
                n = int'(m_if.rd_burst_len);
                for (int i = 0; i < n && !rst; i++) begin
                    rd_pattern = {32'hDA7A_0000, 32'(i)};
                    m_if.rd_burst_data = rd_pattern;
                    m_if.rd_burst_data_valid = 1'b1;
                    @(posedge mem_clk);
                    #1;
                    m_if.rd_burst_data_valid = 1'b0;
                    @(posedge mem_clk);
                    #1;
                end
                while (withhold && !rst) begin
                    @(posedge mem_clk);
                    #1;
                end
                if (!rst) begin
                    m_if.rd_burst_finish = 1'b1;
                    @(posedge mem_clk);
                    #1;
                    m_if.rd_burst_finish = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard grants on master request rise, count strobes and
    // finishes, and let clients drop their request on finish.
    always @(negedge mem_clk) begin
        if (rst) begin
            prev_m_rd = 1'b0;
            prev_m_wr = 1'b0;
        end else begin
            if (m_if.wr_burst_req && !prev_m_wr) begin
                m_wr_rise++;
                pop_compare("wr_grant", key(grant_slot, m_if.wr_burst_addr, m_if.wr_burst_len));
            end
            if (m_if.rd_burst_req && !prev_m_rd) begin
                m_rd_rise++;
                pop_compare("rd_grant", key(grant_slot, m_if.rd_burst_addr, m_if.rd_burst_len));
            end
            prev_m_wr = m_if.wr_burst_req;
            prev_m_rd = m_if.rd_burst_req;
            if (m_if.wr_burst_req && m_if.rd_burst_req) onehot_err++;
            if (c0_if.wr_burst_data_req) begin
                wr_dreq_cnt[0]++;
                if (m_if.wr_burst_data !== c0_if.wr_burst_data) route_err++;
            end
            if (c1_if.wr_burst_data_req) begin
                wr_dreq_cnt[1]++;
                if (m_if.wr_burst_data !== c1_if.wr_burst_data) route_err++;
            end
            if (c0_if.rd_burst_data_valid) begin
                rd_valid_cnt[0]++;
                if (c0_if.rd_burst_data !== rd_pattern) route_err++;
            end
            if (c1_if.rd_burst_data_valid) begin
                rd_valid_cnt[1]++;
                if (c1_if.rd_burst_data !== rd_pattern) route_err++;
            end
            if (c0_if.wr_burst_finish) begin
                fin_cnt[0]++;
                c0_if.wr_burst_req = 1'b0;
            end
            if (c0_if.rd_burst_finish) begin
                fin_cnt[1]++;
                if (!c0_rd_repeat) c0_if.rd_burst_req = 1'b0;
            end
            if (c1_if.wr_burst_finish) begin
                fin_cnt[2]++;
                c1_if.wr_burst_req = 1'b0;
            end
            if (c1_if.rd_burst_finish) begin
                fin_cnt[3]++;
                c1_if.rd_burst_req = 1'b0;
            end
        end
    end

    initial begin : global_limit
        #500_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int k;
        int fin_before;
        c0_if.rd_burst_req = 1'b0; c0_if.wr_burst_req = 1'b0;
        c1_if.rd_burst_req = 1'b0; c1_if.wr_burst_req = 1'b0;
        c0_if.rd_burst_len = '0;   c0_if.wr_burst_len = '0;
        c1_if.rd_burst_len = '0;   c1_if.wr_burst_len = '0;
        c0_if.rd_burst_addr = '0;  c0_if.wr_burst_addr = '0;
        c1_if.rd_burst_addr = '0;  c1_if.wr_burst_addr = '0;
        c0_if.wr_burst_data = 64'hC0C0_0000_1111_2222;
        c1_if.wr_burst_data = 64'hC1C1_0000_3333_4444;
        clear_counts();

        // Reset state
        repeat (3) to_drive();
        rst = 1'b0;
        to_sample();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_slot), 64'd3);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_mreq", 64'({m_if.rd_burst_req, m_if.wr_burst_req}), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // Single c0 write burst, len 128 at 0x100
        clear_counts();
        to_drive();
        c0_if.wr_burst_addr = 32'h100;
        c0_if.wr_burst_len  = 10'd128;
        c0_if.wr_burst_req  = 1'b1;
        exp_q.push_back(key(SLOT_C0_WR, 32'h100, 10'd128));
        to_sample();
        chk("single_mreq_before_grant", 64'(m_if.wr_burst_req), 64'd0);
        to_sample();
        chk("single_mreq_grant_plus1", 64'(m_if.wr_burst_req), 64'd1);
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_grant", 64'(grant_slot), 64'(SLOT_C0_WR));
        chk("single_state", 64'(dbg_state), 64'(ST_ISSUE_WR));
        wait_quiet("single_done", 600);
        chk("single_c0_dreq", 64'(wr_dreq_cnt[0]), 64'd128);
        chk("single_c1_dreq", 64'(wr_dreq_cnt[1]), 64'd0);
        chk("single_finish_pulses", 64'(fin_cnt[0]), 64'd1);
        chk("single_busy_after", 64'(busy), 64'd0);
        chk("single_mreq_after", 64'(m_if.wr_burst_req), 64'd0);
        chk("single_route", 64'(route_err), 64'd0);

        // All four requests together from reset
        do_reset();
        clear_counts();
        c0_if.wr_burst_addr = 32'h1000; c0_if.wr_burst_len = 10'd3;
        c0_if.rd_burst_addr = 32'h1001; c0_if.rd_burst_len = 10'd4;
        c1_if.wr_burst_addr = 32'h1002; c1_if.wr_burst_len = 10'd5;
        c1_if.rd_burst_addr = 32'h1003; c1_if.rd_burst_len = 10'd6;
        exp_q.push_back(key(SLOT_C0_WR, 32'h1000, 10'd3));
        exp_q.push_back(key(SLOT_C0_RD, 32'h1001, 10'd4));
        exp_q.push_back(key(SLOT_C1_WR, 32'h1002, 10'd5));
        exp_q.push_back(key(SLOT_C1_RD, 32'h1003, 10'd6));
        c0_if.wr_burst_req = 1'b1; c0_if.rd_burst_req = 1'b1;
        c1_if.wr_burst_req = 1'b1; c1_if.rd_burst_req = 1'b1;
        to_sample();
        to_sample();
        wait_quiet("all4_done", 2000);
        chk("all4_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("all4_onehot", 64'(onehot_err), 64'd0);
        for (int s = 0; s < 4; s++) chk($sformatf("all4_fin_slot%0d", s), 64'(fin_cnt[s]), 64'd1);
        chk("all4_dreq", 64'({32'(wr_dreq_cnt[0]), 32'(wr_dreq_cnt[1])}), {32'd3, 32'd5});
        chk("all4_valid", 64'({32'(rd_valid_cnt[0]), 32'(rd_valid_cnt[1])}), {32'd4, 32'd6});
        chk("all4_route", 64'(route_err), 64'd0);
        chk("all4_last_grant", 64'(grant_slot), 64'(SLOT_C1_RD));

        // c0_rd keeps re-requesting; c1_wr must still get its turn
        clear_counts();
        to_drive();
        c0_rd_repeat = 1'b1;
        c0_if.rd_burst_addr = 32'h200; c0_if.rd_burst_len = 10'd4;
        c0_if.rd_burst_req = 1'b1;
        exp_q.push_back(key(SLOT_C0_RD, 32'h200, 10'd4));
        repeat (3) to_drive();
        c1_if.wr_burst_addr = 32'h300; c1_if.wr_burst_len = 10'd2;
        c1_if.wr_burst_req = 1'b1;
        exp_q.push_back(key(SLOT_C1_WR, 32'h300, 10'd2));
        exp_q.push_back(key(SLOT_C0_RD, 32'h200, 10'd4));
        k = 0;
        while (fin_cnt[2] == 0 && k < 200) begin
            to_sample();
            k++;
        end
        if (k >= 200) fail_now("starve_c1_wr", "c1_wr never finished");
        c0_rd_repeat = 1'b0;
        wait_quiet("starve_done", 200);
        chk("starve_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("starve_c0rd_fin", 64'(fin_cnt[1]), 64'd2);
        chk("starve_c1wr_fin", 64'(fin_cnt[2]), 64'd1);

        // Read routing to c1 only
        clear_counts();
        to_drive();
        c1_if.rd_burst_addr = 32'h400; c1_if.rd_burst_len = 10'd16;
        c1_if.rd_burst_req = 1'b1;
        exp_q.push_back(key(SLOT_C1_RD, 32'h400, 10'd16));
        to_sample();
        to_sample();
        wait_quiet("route_done", 200);
        chk("route_c1_valid", 64'(rd_valid_cnt[1]), 64'd16);
        chk("route_c0_valid", 64'(rd_valid_cnt[0]), 64'd0);
        chk("route_data", 64'(route_err), 64'd0);
        chk("route_c1_fin", 64'(fin_cnt[3]), 64'd1);

        // Zero-length c1 write
        clear_counts();
        to_drive();
        c1_if.wr_burst_addr = 32'h500; c1_if.wr_burst_len = 10'd0;
        c1_if.wr_burst_req = 1'b1;
        to_sample();
        chk("zero_fin_early", 64'(c1_if.wr_burst_finish), 64'd0);
        to_sample();
        chk("zero_fin_pulse", 64'(c1_if.wr_burst_finish), 64'd1);
        chk("zero_mreq", 64'(m_if.wr_burst_req), 64'd0);
        chk("zero_state", 64'(dbg_state), 64'(ST_NULL_DONE));
        to_sample();
        chk("zero_fin_after", 64'(c1_if.wr_burst_finish), 64'd0);
        chk("zero_busy_after", 64'(busy), 64'd0);
        chk("zero_no_mreq_rise", 64'(m_wr_rise), 64'd0);
        chk("zero_fin_count", 64'(fin_cnt[2]), 64'd1);

        // Stray master strobes while idle
        to_drive();
        m_if.wr_burst_data_req = 1'b1; m_if.rd_burst_data_valid = 1'b1;
        m_if.rd_burst_finish = 1'b1;   m_if.wr_burst_finish = 1'b1;
        to_sample();
        chk("stray_client_outs",
            64'({c0_if.wr_burst_data_req, c1_if.wr_burst_data_req,
                 c0_if.rd_burst_data_valid, c1_if.rd_burst_data_valid,
                 c0_if.wr_burst_finish, c0_if.rd_burst_finish,
                 c1_if.wr_burst_finish, c1_if.rd_burst_finish}), 64'd0);
        to_drive();
        m_if.wr_burst_data_req = 1'b0; m_if.rd_burst_data_valid = 1'b0;
        m_if.rd_burst_finish = 1'b0;   m_if.wr_burst_finish = 1'b0;
        to_sample();
        chk("stray_busy", 64'(busy), 64'd0);

        // Watchdog with finish withheld
        do_reset();
        clear_counts();
        to_sample();
        chk("wd_timeout_clear", 64'(timeout), 64'd0);
        to_drive();
        withhold = 1'b1;
        c0_if.rd_burst_addr = 32'h600; c0_if.rd_burst_len = 10'd2;
        c0_if.rd_burst_req = 1'b1;
        exp_q.push_back(key(SLOT_C0_RD, 32'h600, 10'd2));
        repeat (51) to_sample();
        chk("wd_before_limit", 64'(timeout), 64'd0);
        to_sample();
        chk("wd_at_limit", 64'(timeout), 64'd1);
        chk("wd_not_aborted", 64'({busy, m_if.rd_burst_req}), 64'd3);
        chk("wd_state", 64'(dbg_state), 64'(ST_ISSUE_RD));

        // Reset while in ISSUE_RD
        fin_before = fin_cnt[1];
        to_drive();
        rst = 1'b1;
        to_sample();
        chk("rst_mid_no_fin_now", 64'(c0_if.rd_burst_finish), 64'd0);
        to_sample();
        chk("rst_mid_mreq", 64'(m_if.rd_burst_req), 64'd0);
        chk("rst_mid_grant", 64'(grant_slot), 64'd3);
        chk("rst_mid_busy_timeout", 64'({busy, timeout}), 64'd0);
        chk("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));
        c0_if.rd_burst_req = 1'b0;
        withhold = 1'b0;
        to_drive();
        rst = 1'b0;
        repeat (4) to_sample();
        chk("rst_mid_no_fin", 64'(fin_cnt[1]), 64'(fin_before));
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
